// File: rtl/regm_wb.sv
// Write-back arbiter for the register memory's single write port: primary pipeline
// results take priority, and long-latency results wait in a small FIFO with WAW kill.
module regm_wb #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_valid,
    input  logic [4:0]               wb_reg,
    input  logic [31:0]              wb_data,
    input  logic                     lu_valid,
    output logic                     lu_ready,
    input  logic [4:0]               lu_reg,
    input  logic [31:0]              lu_data,
    output logic                     regwrite,
    output logic [4:0]               wrreg,
    output logic [31:0]              wrdata,
    input  logic [4:0]               chk_reg1,
    input  logic [4:0]               chk_reg2,
    output logic                     busy1,
    output logic                     busy2,
    output logic                     wb_stall,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_MAX) + 1;
    localparam logic [AW:0]   FULL       = (AW+1)'(DEPTH);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX - 1);

    logic [4:0]       ent_reg_q  [DEPTH];
    logic [31:0]      ent_data_q [DEPTH];
    logic [DEPTH-1:0] ent_vld_q;
    logic [AW-1:0]    head_q, tail_q;
    logic [AW:0]      count_q, count_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             stall_q, stall_d;
    logic             we_q, we_d;
    logic [4:0]       wrreg_q, wrreg_d;
    logic [31:0]      wrdata_q, wrdata_d;

    logic empty, accept, prim, pop, bypass, push;

    // lu_ready depends only on registered occupancy, so a pop cannot free a slot in the same cycle
    assign empty    = (count_q == '0);
    assign lu_ready = (count_q != FULL);
    assign accept   = lu_valid && lu_ready;
    assign prim     = wb_valid && (wb_reg != 5'd0);
    assign pop      = !prim && !empty;
    assign bypass   = !prim && empty && accept && (lu_reg != 5'd0);
    assign push     = accept && (lu_reg != 5'd0) && !bypass;

    always_comb begin
        we_d     = 1'b0;
        wrreg_d  = wrreg_q;
        wrdata_d = wrdata_q;
        if (prim) begin
            we_d     = 1'b1;
            wrreg_d  = wb_reg;
            wrdata_d = wb_data;
        end else if (pop) begin
            if (ent_vld_q[head_q]) begin
                we_d     = 1'b1;
                wrreg_d  = ent_reg_q[head_q];
                wrdata_d = ent_data_q[head_q];
            end
        end else if (bypass) begin
            we_d     = 1'b1;
            wrreg_d  = lu_reg;
            wrdata_d = lu_data;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        starve_d = '0;
        stall_d  = 1'b0;
        if (!empty && !pop) begin
            stall_d  = (starve_q == STARVE_TOP);
            starve_d = (starve_q == STARVE_TOP) ? starve_q : starve_q + SW'(1);
        end
    end

    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld_q[i] && ent_reg_q[i] == chk_reg1) busy1 = 1'b1;
            if (ent_vld_q[i] && ent_reg_q[i] == chk_reg2) busy2 = 1'b1;
        end
        if (we_q && wrreg_q == chk_reg1) busy1 = 1'b1;
        if (we_q && wrreg_q == chk_reg2) busy2 = 1'b1;
        if (chk_reg1 == 5'd0) busy1 = 1'b0;
        if (chk_reg2 == 5'd0) busy2 = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg_q[i]  <= '0;
                ent_data_q[i] <= '0;
            end
            ent_vld_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            stall_q   <= 1'b0;
            we_q      <= 1'b0;
            wrreg_q   <= '0;
            wrdata_q  <= '0;
        end else begin
            if (prim) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (ent_reg_q[i] == wb_reg) ent_vld_q[i] <= 1'b0;
                end
            end
            if (pop) begin
                ent_vld_q[head_q] <= 1'b0;
                head_q            <= head_q + AW'(1);
            end
            // Later assignment wins: a beat pushed alongside a kill is younger and stays valid
            if (push) begin
                ent_vld_q[tail_q]  <= 1'b1;
                ent_reg_q[tail_q]  <= lu_reg;
                ent_data_q[tail_q] <= lu_data;
                tail_q             <= tail_q + AW'(1);
            end
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            we_q     <= we_d;
            wrreg_q  <= wrreg_d;
            wrdata_q <= wrdata_d;
        end
    end

    assign regwrite = we_q;
    assign wrreg    = wrreg_q;
    assign wrdata   = wrdata_q;
    assign wb_stall = stall_q;
    assign count    = count_q;

endmodule

// File: tb/tb_regm_wb.sv
// Scoreboard bench for regm_wb: a queue-based reference model predicts each cycle's
// response, and an independent monitor compares the DUT against it.
module tb_regm_wb;

    localparam int DEPTH = 4;
    localparam int SM    = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid, lu_valid, lu_ready, regwrite, busy1, busy2, wb_stall;
    logic [4:0]  wb_reg, lu_reg, wrreg, chk_reg1, chk_reg2;
    logic [31:0] wb_data, lu_data, wrdata;
    logic [2:0]  count;

    regm_wb #(.DEPTH(DEPTH), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_reg(lu_reg), .lu_data(lu_data),
        .regwrite(regwrite), .wrreg(wrreg), .wrdata(wrdata),
        .chk_reg1(chk_reg1), .chk_reg2(chk_reg2), .busy1(busy1), .busy2(busy2),
        .wb_stall(wb_stall), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        bit          v;
    } ent_t;

    typedef struct {
        bit          b1, b2, rdy, we, stall;
        logic [4:0]  wr;
        logic [31:0] wd;
        int          cnt;
    } exp_t;

    ent_t        mq[$];
    exp_t        sb[$];
    bit          m_we;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    int          waited;
    bit          m_stall;
    int          errors = 0;
    int          checks = 0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_we    = 1'b0;
        m_reg   = '0;
        m_data  = '0;
        waited  = 0;
        m_stall = 1'b0;
    endfunction

    function automatic bit m_busy(input logic [4:0] c);
        if (c == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].v && mq[i].r == c) return 1'b1;
        return m_we && (m_reg == c);
    endfunction

    task automatic drive(input bit wv, input logic [4:0] wr, input logic [31:0] wd,
                         input bit lv, input logic [4:0] lr, input logic [31:0] ld,
                         input logic [4:0] c1, input logic [4:0] c2);
        exp_t e;
        ent_t h;
        bit   accept, prim, nonempty, popped, byp;
        @(negedge clk);
        wb_valid = wv; wb_reg = wr; wb_data = wd;
        lu_valid = lv; lu_reg = lr; lu_data = ld;
        chk_reg1 = c1; chk_reg2 = c2;
        e.b1  = m_busy(c1);
        e.b2  = m_busy(c2);
        e.rdy = (mq.size() != DEPTH);
        accept   = lv && e.rdy;
        prim     = wv && (wr != 5'd0);
        nonempty = (mq.size() > 0);
        popped   = 1'b0;
        byp      = 1'b0;
        if (prim) begin
            m_we = 1'b1; m_reg = wr; m_data = wd;
            foreach (mq[i]) if (mq[i].r == wr) mq[i].v = 1'b0;
        end else if (nonempty) begin
            h = mq.pop_front();
            popped = 1'b1;
            if (h.v) begin
                m_we = 1'b1; m_reg = h.r; m_data = h.d;
            end else begin
                m_we = 1'b0;
            end
        end else if (accept && lr != 5'd0) begin
            m_we = 1'b1; m_reg = lr; m_data = ld;
            byp = 1'b1;
        end else begin
            m_we = 1'b0;
        end
        if (accept && lr != 5'd0 && !byp) mq.push_back('{r: lr, d: ld, v: 1'b1});
        if (nonempty && !popped) begin
            waited++;
            m_stall = (waited >= SM);
        end else begin
            waited  = 0;
            m_stall = 1'b0;
        end
        e.we    = m_we;
        e.wr    = m_reg;
        e.wd    = m_data;
        e.cnt   = mq.size();
        e.stall = m_stall;
        sb.push_back(e);
    endtask

    task automatic idle(input logic [4:0] c1, input logic [4:0] c2);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, c1, c2);
    endtask

    // Monitor: combinational lookups sampled mid-cycle, registered outputs just after the edge
    initial begin
        exp_t e;
        bit   s_b1, s_b2, s_rdy;
        forever begin
            @(negedge clk);
            #2;
            s_b1  = busy1;
            s_b2  = busy2;
            s_rdy = lu_ready;
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("busy1",    32'(s_b1),     32'(e.b1));
                check("busy2",    32'(s_b2),     32'(e.b2));
                check("lu_ready", 32'(s_rdy),    32'(e.rdy));
                check("regwrite", 32'(regwrite), 32'(e.we));
                check("wrreg",    32'(wrreg),    32'(e.wr));
                check("wrdata",   wrdata,        e.wd);
                check("count",    32'(count),    32'(e.cnt));
                check("wb_stall", 32'(wb_stall), 32'(e.stall));
            end
        end
    end

    initial begin
        reset = 1'b1;
        wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
        lu_valid = 1'b0; lu_reg = '0; lu_data = '0;
        chk_reg1 = '0; chk_reg2 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_regwrite", 32'(regwrite), 32'd0);
        check("rst_count",    32'(count),    32'd0);
        check("rst_lu_ready", 32'(lu_ready), 32'd1);
        check("rst_wb_stall", 32'(wb_stall), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        drive(1'b1, 5'd5, 32'hAAAA0001, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h12345678, 5'd9, 5'd0);
        idle(5'd9, 5'd0);

        // Primary every cycle while four beats fill the FIFO, then drain in order
        for (int i = 1; i <= 6; i++)
            drive(1'b1, 5'(i), 32'h100 + 32'(i), 1'b1, (i <= 4) ? 5'(9 + i) : 5'd14,
                  32'hB000 + 32'(i), 5'd0, 5'd11);
        for (int i = 0; i < 5; i++) idle(5'd0, 5'd11);

        // WAW kill of a queued entry
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd7, 32'h1, 5'd7, 5'd8);
        drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd8, 32'h2, 5'd7, 5'd8);
        drive(1'b1, 5'd7, 32'h3,  1'b1, 5'd7, 32'h4, 5'd7, 5'd8);
        for (int i = 0; i < 5; i++) idle(5'd7, 5'd8);

        // Starvation, stall held while primary continues, release on one idle cycle
        drive(1'b1, 5'd1, 32'h55, 1'b1, 5'd20, 32'h2020, 5'd20, 5'd0);
        for (int i = 0; i < 10; i++) drive(1'b1, 5'(2 + i), 32'h60 + 32'(i), 1'b0, 5'd0, 32'd0, 5'd20, 5'd0);
        idle(5'd20, 5'd0);
        idle(5'd20, 5'd0);

        // r0 beats and r0 primary writes
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD, 5'd0, 5'd0);
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd11, 32'hC11, 5'd0, 5'd11);
        drive(1'b1, 5'd0, 32'h99, 1'b1, 5'd0, 32'hBEEF, 5'd0, 5'd11);
        idle(5'd0, 5'd11);

        // Reset mid-stream with three queued entries
        for (int i = 0; i < 3; i++)
            drive(1'b1, 5'd1, 32'h70 + 32'(i), 1'b1, 5'(21 + i), 32'hE0 + 32'(i), 5'd21, 5'd0);
        @(posedge clk);
        #3;
        wb_valid = 1'b0; lu_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rst_regwrite", 32'(regwrite), 32'd0);
        check("mid_rst_wrreg",    32'(wrreg),    32'd0);
        check("mid_rst_wrdata",   wrdata,        32'd0);
        check("mid_rst_count",    32'(count),    32'd0);
        check("mid_rst_lu_ready", 32'(lu_ready), 32'd1);
        check("mid_rst_busy1",    32'(busy1),    32'd0);
        check("mid_rst_wb_stall", 32'(wb_stall), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 5'd5, 32'hAAAA0001, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);

        for (int i = 0; i < 3000; i++)
            drive(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom(),
                  ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom(),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

        for (int i = 0; i < 8; i++) idle(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        @(posedge clk);
        #3;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regm_wb.md
Name: regm_wb

Overview:
- Write-back arbiter and buffer that drives the single write port (regwrite/wrreg/wrdata) of the 32x32 register memory.
- Merges two result sources:
  - the in-order pipeline MEM/WB result, which is primary and always accepted;
  - the long-latency unit result, which is secondary, handshaked, and buffered in a small FIFO.
- Provides pending-register lookups so decode can stall on results still queued, and requests a pipeline bubble when the FIFO head starves.

Parameters:
DEPTH, 4, secondary FIFO entries (power of two, >=2)
STARVE_MAX, 8, consecutive cycles the FIFO head may wait before wb_stall asserts

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
wb_valid  input  1  primary result valid this cycle
wb_reg  input  5  primary destination register
wb_data  input  32  primary result
lu_valid  input  1  secondary result offered
lu_ready  output  1  FIFO can accept; a beat transfers when lu_valid && lu_ready
lu_reg  input  5  secondary destination register
lu_data  input  32  secondary result
regwrite  output  1  registered write enable to register memory
wrreg  output  5  registered write address
wrdata  output  32  registered write data
chk_reg1  input  5  decode source register 1 to check
chk_reg2  input  5  decode source register 2 to check
busy1  output  1  chk_reg1 is pending (combinational)
busy2  output  1  chk_reg2 is pending (combinational)
wb_stall  output  1  registered request: pipeline must present no primary result next cycle
count  output  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (asynchronous, immediate):
  - regwrite=0, wrreg=0, wrdata=0, wb_stall=0, count=0.
  - All FIFO entries invalid; starvation counter=0.
  - Any in-flight state is discarded.
- Output stage: registered, one-cycle latency. The source selected in cycle N appears on regwrite/wrreg/wrdata in cycle N+1.
- Selection each cycle, in priority order:
  1. wb_valid && wb_reg!=0: load primary into the output stage.
  2. Else, FIFO non-empty: pop head. Valid head loads the output stage with regwrite=1. Killed head gives regwrite=0 that cycle.
  3. Else, accepted lu beat with lu_reg!=0: bypass straight into the output stage; nothing stored.
  4. Else: regwrite=0; wrreg/wrdata hold their last values.
- Register 0:
  - Primary writes to r0 count as idle; the FIFO may pop that cycle.
  - Secondary beats to r0 are handshaked (accepted) but never stored or written.
- lu_ready = (count != DEPTH), derived from registered state only.
  - Push and pop in the same cycle is allowed; count is unchanged.
  - In a full FIFO, a pop does not open a slot for the same cycle's beat.
- Secondary beats not bypassed push at the tail with valid=1.
- WAW kill: a primary write to register R (R!=0) clears valid on every FIFO entry whose reg==R, in the same cycle.
  - A beat to R pushed in that same cycle is not killed (it is younger).
- Pending lookups:
  - busyN=1 iff chk_regN!=0 and it matches a valid FIFO entry, or it matches wrreg while regwrite=1.
  - Register memory forwards same-cycle writes, so the output-stage match is conservative but required.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and does not pop; it clears on any pop or when the FIFO is empty.
  - When counter==STARVE_MAX-1 and no pop occurs, wb_stall=1 next cycle.
  - wb_stall clears the cycle after a pop.
  - If wb_valid arrives while wb_stall=1, primary still wins; the counter saturates and wb_stall stays high.
- Pointers wrap modulo DEPTH.
- count ranges 0..DEPTH. Never overflows: push only with lu_ready. Never underflows: pop only when non-empty.

Test Plan:
- Reset sequence:
  - Assert reset mid-stream with 3 entries queued: outputs go to 0 immediately, count=0, lu_ready=1, busy1=0 for a previously queued register.
  - Deassert reset, then wb_valid with reg 5, data 0xAAAA0001 -> next cycle regwrite=1, wrreg=5, wrdata=0xAAAA0001.
- Bypass: FIFO empty, no primary, lu beat reg 9, data 0x12345678 -> next cycle wrreg=9, wrdata=0x12345678; count stays 0.
- Priority and fill:
  - Primary valid every cycle (regs 1..6), lu pushes regs 10,11,12,13 -> count reaches 4, lu_ready=0, no lu writes appear.
  - Primary idles -> writes appear in order 10,11,12,13 on consecutive cycles.
- WAW kill:
  - Queue reg 7 (0x1) and reg 8 (0x2), then primary reg 7 (0x3) -> busy for 7 clears once output is done.
  - Pops: entry 7 gives a regwrite=0 cycle, entry 8 writes 0x2; register 7 is never overwritten with 0x1.
- Starvation: STARVE_MAX=8, one queued entry, primary valid continuously -> wb_stall=1 after 8 cycles; primary drops for one cycle -> head pops, wb_stall=0 the following cycle.
- r0 and lookups:
  - lu beat to reg 0 -> accepted, count unchanged, no write.
  - chk_reg1=0 -> busy1=0 always; chk_reg2=11 with 11 queued -> busy2=1.
